// File: rtl/barret_pkg.sv
// barret_pkg
// Shared constants and elaboration helpers for the Barrett reduction blocks.
//   Q_KYBER / Q_DEF : commonly used moduli
//   mu_of()         : Barrett constant floor(2^(2k) / q)
//   params_ok()     : legality check for a reducer parameter set
package barret_pkg;

  localparam int unsigned Q_KYBER = 3329;
  localparam int unsigned Q_DEF   = 2789;

  // The numerator can reach 2^32 for a 16-bit modulus, so the division is
  // carried out in 64 bits before narrowing the quotient back down.
  function automatic int unsigned mu_of(input int unsigned q, input int unsigned k);
    longint unsigned num;
    num = 64'd1 << (2 * k);
    return 32'(num / 64'(q));
  endfunction

  // A set of parameters is usable when the operand fits the 2K-bit Barrett
  // window, the modulus is odd and in range, and the tag has at least one bit.
  function automatic bit params_ok(input int unsigned q, input int unsigned k,
                                   input int unsigned w_in, input int unsigned tag_w);
    return (w_in >= 1) && (w_in <= 2 * k) && (q >= 3) && (q < 65536) &&
           ((q % 2) == 1) && (tag_w >= 1);
  endfunction

endpackage

// File: rtl/barret_reduce_pipe_csub.sv
// barret_csub
// Combinational single conditional subtraction: o_y = (i_a >= Q) ? i_a - Q : i_a,
// resized to W_OUT bits.
//   i_a : W-bit unsigned operand
//   o_y : W_OUT-bit result
module barret_csub
  import barret_pkg::*;
#(
  parameter int unsigned W     = 14,
  parameter int unsigned W_OUT = 14,
  parameter int unsigned Q     = Q_DEF
) (
  input  logic [W-1:0]     i_a,
  output logic [W_OUT-1:0] o_y
);

  logic [W-1:0] w_q;
  logic [W-1:0] w_diff;

  assign w_q    = W'(Q);
  assign w_diff = i_a - w_q;

  // The caller guarantees the selected value fits in W_OUT bits, so the
  // narrowing only drops bits that are known to be zero.
  assign o_y = W_OUT'((i_a >= w_q) ? w_diff : i_a);

endmodule

// File: rtl/barret_reduce_pipe.sv
// barret_reduce_pipe
// Three-stage streaming Barrett reducer: dout = din mod Q, with a side-band
// tag carried alongside each operand. A single global stall holds every stage
// while the output register is occupied and not being taken.
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid / in_ready  : input handshake
//   din, in_tag          : operand and its tag
//   out_valid / out_ready: output handshake
//   dout, out_tag        : reduced result and the tag it was accepted with
module barret_reduce_pipe
  import barret_pkg::*;
#(
  parameter int unsigned Q     = Q_DEF,
  parameter int unsigned W_IN  = 23,
  parameter int unsigned TAG_W = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [W_IN-1:0]        din,
  input  logic [TAG_W-1:0]       in_tag,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [$clog2(Q)-1:0]   dout,
  output logic [TAG_W-1:0]       out_tag
);

  localparam int unsigned K      = $clog2(Q);
  localparam int unsigned MU     = mu_of(Q, K);
  localparam int unsigned W_OUT  = K;
  localparam int unsigned W_MU   = $clog2(MU + 1);
  // When the operand is no wider than K the high part is always zero; one
  // bit keeps the vectors legal in that case.
  localparam int unsigned W_HI   = (W_IN > K) ? (W_IN - K) : 1;
  localparam int unsigned W_QH   = W_HI + W_MU;
  localparam int unsigned W_T    = (W_QH > K) ? (W_QH - K) : 1;
  // Remainder before correction is below 3Q < 2^(K+2).
  localparam int unsigned W_R    = K + 2;
  localparam int unsigned W_WIDE = W_T + 17;

  if (!params_ok(Q, K, W_IN, TAG_W)) begin : g_param_error
    $error("barret_reduce_pipe: illegal parameter set (need Q odd, 3<=Q<2^16, W_IN<=2K, TAG_W>=1)");
  end

  logic                 w_adv;
  logic [W_HI-1:0]      w_dinHi;
  logic [W_QH-1:0]      w_qHat;
  logic [W_T-1:0]       w_t;
  logic [W_WIDE-1:0]    w_tqFull;
  logic [W_R-1:0]       w_dinLo;
  logic [W_R-1:0]       w_tqLo;
  logic [W_R-1:0]       w_r;
  logic [W_R-1:0]       w_r1;
  logic [W_OUT-1:0]     w_red;

  logic                 r_v1;
  logic [W_IN-1:0]      r_din1;
  logic [W_QH-1:0]      r_qHat1;
  logic [TAG_W-1:0]     r_tag1;
  logic                 r_v2;
  logic [W_R-1:0]       r_r2;
  logic [TAG_W-1:0]     r_tag2;
  logic                 r_v3;
  logic [W_OUT-1:0]     r_dout3;
  logic [TAG_W-1:0]     r_tag3;

  // Whole pipeline moves together: it advances whenever the output slot is
  // empty or is being drained this cycle, so bubbles are never squeezed out.
  assign w_adv    = out_ready || !r_v3;
  assign in_ready = w_adv;

  // Stage 1 estimate of the quotient numerator; the product is kept at full
  // width so no bits of q_hat are lost.
  assign w_dinHi = W_HI'(din >> K);
  assign w_qHat  = W_QH'(w_dinHi) * W_QH'(MU);

  // Stage 2 remainder. The true value is below 2^(K+2), so computing the
  // subtraction modulo 2^(K+2) gives the exact result.
  assign w_t      = W_T'(r_qHat1 >> K);
  assign w_tqFull = W_WIDE'(w_t) * W_WIDE'(Q);
  assign w_tqLo   = W_R'(w_tqFull);
  assign w_dinLo  = W_R'(r_din1);
  assign w_r      = w_dinLo - w_tqLo;

  // Stage 3 brings r from [0, 3Q) into [0, Q) with two corrections.
  barret_csub #(
    .W     (W_R),
    .W_OUT (W_R),
    .Q     (Q)
  ) u_csub0 (
    .i_a (r_r2),
    .o_y (w_r1)
  );

  barret_csub #(
    .W     (W_R),
    .W_OUT (W_OUT),
    .Q     (Q)
  ) u_csub1 (
    .i_a (w_r1),
    .o_y (w_red)
  );

  // Stage registers with valid and tag carried in lockstep with the data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v1    <= 1'b0;
      r_din1  <= '0;
      r_qHat1 <= '0;
      r_tag1  <= '0;
      r_v2    <= 1'b0;
      r_r2    <= '0;
      r_tag2  <= '0;
      r_v3    <= 1'b0;
      r_dout3 <= '0;
      r_tag3  <= '0;
    end else if (w_adv) begin
      r_v1    <= in_valid;
      r_din1  <= din;
      r_qHat1 <= w_qHat;
      r_tag1  <= in_tag;
      r_v2    <= r_v1;
      r_r2    <= w_r;
      r_tag2  <= r_tag1;
      r_v3    <= r_v2;
      r_dout3 <= w_red;
      r_tag3  <= r_tag2;
    end
  end

  assign out_valid = r_v3;
  assign dout      = r_dout3;
  assign out_tag   = r_tag3;

endmodule
